uart_pkt_serializer: RTL and testbench

//   Parametrised packet-to-byte serializer for the UART TX path. Buffers up to FIFO_DEPTH

---
 rtl/uart_pkt_serializer.sv | 200 ++++++++++++++++++++
 tb/tb_uart_pkt_serializer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_pkt_serializer.sv
// Packet-to-byte serializer for the UART TX path: queues wide packets in a small FIFO
// and streams each one byte by byte through a send/busy handshake with the UART core.
`timescale 1ns/1ps
module uart_pkt_serializer #(
    parameter int unsigned N_BYTES    = 51,
    parameter int unsigned LSB_FIRST  = 0,
    parameter int unsigned FIFO_DEPTH = 2,
    parameter int unsigned BUSY_LAT   = 2,
    parameter int unsigned GAP_CYC    = 0
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [8*N_BYTES-1:0]             pkt_data,
    input  logic [$clog2(N_BYTES+1)-1:0]     pkt_len,
    input  logic                             pkt_valid,
    output logic                             pkt_ready,
    input  logic                             abort,
    input  logic                             tx_busy,
    output logic [7:0]                       tx_data,
    output logic                             tx_send,
    output logic                             done,
    output logic                             overflow,
    output logic                             active
);

    localparam int unsigned LW   = $clog2(N_BYTES + 1);
    localparam int unsigned DW   = 8 * N_BYTES;
    localparam int unsigned PW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW   = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned BL   = (BUSY_LAT > 0) ? BUSY_LAT : 1;
    localparam int unsigned GC   = (GAP_CYC > 0) ? GAP_CYC : 1;
    localparam int unsigned TMAX = (BL > GC) ? BL : GC;
    localparam int unsigned TW   = $clog2(TMAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SEND,
        S_WAIT_HI,
        S_WAIT_LO,
        S_GAP,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [DW-1:0]   mem_data_q [FIFO_DEPTH];
    logic [DW-1:0]   mem_data_d [FIFO_DEPTH];
    logic [LW-1:0]   mem_len_q  [FIFO_DEPTH];
    logic [LW-1:0]   mem_len_d  [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            ready_q, ready_d;
    logic            overflow_q, overflow_d;
    logic [DW-1:0]   shreg_q, shreg_d;
    logic [LW-1:0]   cnt_q, cnt_d;
    logic [TW-1:0]   timer_q, timer_d;

    logic            wr_en;
    logic            rd_en;
    logic [LW-1:0]   head_len;
    logic [LW-1:0]   eff_len;
    logic [7:0]      cur_byte;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign pkt_ready = ready_q;
    assign overflow  = overflow_q;
    assign active    = (state_q != S_IDLE);
    assign head_len  = mem_len_q[rd_ptr_q];
    assign eff_len   = (head_len == '0 || head_len > LW'(N_BYTES)) ? LW'(N_BYTES) : head_len;
    assign cur_byte  = (LSB_FIRST != 0) ? shreg_q[7:0] : shreg_q[DW-1 -: 8];

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        cnt_d      = cnt_q;
        timer_d    = timer_q;
        tx_send    = 1'b0;
        tx_data    = '0;
        done       = 1'b0;
        rd_en      = 1'b0;
        wr_en      = pkt_valid && ready_q && !abort;

        case (state_q)
            S_IDLE: begin
                if (count_q != '0) state_d = S_LOAD;
            end
            S_LOAD: begin
                rd_en   = 1'b1;
                shreg_d = mem_data_q[rd_ptr_q];
                cnt_d   = eff_len;
                state_d = S_SEND;
            end
            S_SEND: begin
                if (!tx_busy) begin
                    tx_send = 1'b1;
                    tx_data = cur_byte;
                    shreg_d = (LSB_FIRST != 0) ? (shreg_q >> 8) : (shreg_q << 8);
                    if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
                    timer_d = '0;
                    state_d = S_WAIT_HI;
                end
            end
            S_WAIT_HI: begin
                // A UART that never raises busy is released after BUSY_LAT cycles.
                if (tx_busy || timer_q == TW'(BL - 1)) begin
                    timer_d = '0;
                    state_d = S_WAIT_LO;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_WAIT_LO: begin
                if (!tx_busy) begin
                    timer_d = '0;
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                if (timer_q == TW'(GC - 1)) begin
                    timer_d = '0;
                    state_d = (cnt_q != '0) ? S_SEND : S_DONE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (abort) begin
            state_d = S_IDLE;
            tx_send = 1'b0;
            tx_data = '0;
            done    = 1'b0;
            rd_en   = 1'b0;
        end

        mem_data_d = mem_data_q;
        mem_len_d  = mem_len_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        if (wr_en) begin
            mem_data_d[wr_ptr_q] = pkt_data;
            mem_len_d[wr_ptr_q]  = pkt_len;
            wr_ptr_d             = ptr_inc(wr_ptr_q);
        end
        if (rd_en) rd_ptr_d = ptr_inc(rd_ptr_q);
        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        if (abort) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end

        ready_d    = (count_d != CW'(FIFO_DEPTH));
        overflow_d = overflow_q | (pkt_valid & ~ready_q & ~abort);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ready_q    <= 1'b1;
            overflow_q <= 1'b0;
            shreg_q    <= '0;
            cnt_q      <= '0;
            timer_q    <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            ready_q    <= ready_d;
            overflow_q <= overflow_d;
            shreg_q    <= shreg_d;
            cnt_q      <= cnt_d;
            timer_q    <= timer_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_data_q <= mem_data_d;
        mem_len_q  <= mem_len_d;
    end

endmodule

// File: tb/tb_uart_pkt_serializer.sv
// Directed bench for uart_pkt_serializer: an MSB-first instance (no gap) and an
// LSB-first instance (GAP_CYC=3), each driven by a small UART busy model.
`timescale 1ns/1ps
module tb_uart_pkt_serializer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n = 1'b0;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_fail = 0;

    logic [31:0] pkt_data_a = '0, pkt_data_b = '0;
    logic [2:0]  pkt_len_a = '0, pkt_len_b = '0;
    logic        pkt_valid_a = 1'b0, pkt_valid_b = 1'b0;
    logic        abort_a = 1'b0, abort_b = 1'b0;
    logic        tx_busy_a = 1'b0, tx_busy_b = 1'b0;
    logic        pkt_ready_a, pkt_ready_b;
    logic [7:0]  tx_data_a, tx_data_b;
    logic        tx_send_a, tx_send_b;
    logic        done_a, done_b;
    logic        overflow_a, overflow_b;
    logic        active_a, active_b;

    uart_pkt_serializer #(.N_BYTES(4), .LSB_FIRST(0), .FIFO_DEPTH(2), .BUSY_LAT(2), .GAP_CYC(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .pkt_data(pkt_data_a), .pkt_len(pkt_len_a),
        .pkt_valid(pkt_valid_a), .pkt_ready(pkt_ready_a), .abort(abort_a),
        .tx_busy(tx_busy_a), .tx_data(tx_data_a), .tx_send(tx_send_a),
        .done(done_a), .overflow(overflow_a), .active(active_a)
    );

    uart_pkt_serializer #(.N_BYTES(4), .LSB_FIRST(1), .FIFO_DEPTH(2), .BUSY_LAT(2), .GAP_CYC(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .pkt_data(pkt_data_b), .pkt_len(pkt_len_b),
        .pkt_valid(pkt_valid_b), .pkt_ready(pkt_ready_b), .abort(abort_b),
        .tx_busy(tx_busy_b), .tx_data(tx_data_b), .tx_send(tx_send_b),
        .done(done_b), .overflow(overflow_b), .active(active_b)
    );

    // UART models: busy for busy_cyc cycles after each send (0 = busy never rises)
    int busy_cyc_a = 10, busy_cyc_b = 10;
    int left_a = 0, left_b = 0;
    always @(posedge clk) begin
        if (tx_send_a && busy_cyc_a != 0) begin
            tx_busy_a <= 1'b1;
            left_a    <= busy_cyc_a;
        end else if (left_a > 1) begin
            left_a <= left_a - 1;
        end else begin
            left_a    <= 0;
            tx_busy_a <= 1'b0;
        end
        if (tx_send_b && busy_cyc_b != 0) begin
            tx_busy_b <= 1'b1;
            left_b    <= busy_cyc_b;
        end else if (left_b > 1) begin
            left_b <= left_b - 1;
        end else begin
            left_b    <= 0;
            tx_busy_b <= 1'b0;
        end
    end

    logic [7:0] byte_a[$], byte_b[$];
    int         scyc_a[$], scyc_b[$];
    int         ndone_a = 0, ndone_b = 0;
    always @(negedge clk) begin
        if (tx_send_a) begin
            byte_a.push_back(tx_data_a);
            scyc_a.push_back(cyc);
        end
        if (tx_send_b) begin
            byte_b.push_back(tx_data_b);
            scyc_b.push_back(cyc);
        end
        if (done_a) ndone_a++;
        if (done_b) ndone_b++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic int level(input int sel);
        case (sel)
            0:       return byte_a.size();
            1:       return ndone_a;
            2:       return byte_b.size();
            default: return ndone_b;
        endcase
    endfunction

    task automatic wait_until(input int sel, input int n, input string tag);
        int k = 0;
        while (level(sel) < n && k < 400) begin
            @(negedge clk);
            #1;
            k++;
        end
        chk(tag, 32'(level(sel) >= n), 32'd1);
    endtask

    int t_acc;
    int nd;

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready_a",    32'(pkt_ready_a), 32'd1);
        chk("rst_active_a",   32'(active_a),    32'd0);
        chk("rst_send_a",     32'(tx_send_a),   32'd0);
        chk("rst_done_a",     32'(done_a),      32'd0);
        chk("rst_overflow_a", 32'(overflow_a),  32'd0);
        chk("rst_ready_b",    32'(pkt_ready_b), 32'd1);
        @(posedge clk); #1 rst_n = 1'b1;

        // MSB-first, len 0 means full packet; latency check
        @(posedge clk); #1;
        pkt_data_a = 32'hA1B2C3D4; pkt_len_a = 3'd0; pkt_valid_a = 1'b1;
        @(negedge clk); t_acc = cyc;
        @(posedge clk); #1 pkt_valid_a = 1'b0;
        wait_until(1, 1, "t1_done_timeout");
        chk("t1_nbytes", 32'(byte_a.size()), 32'd4);
        chk("t1_b0", 32'(byte_a[0]), 32'hA1);
        chk("t1_b1", 32'(byte_a[1]), 32'hB2);
        chk("t1_b2", 32'(byte_a[2]), 32'hC3);
        chk("t1_b3", 32'(byte_a[3]), 32'hD4);
        chk("t1_latency", 32'(scyc_a[0]), 32'(t_acc + 3));
        @(negedge clk);
        chk("t1_idle_after_done", 32'(active_a), 32'd0);
        chk("t1_ndone", 32'(ndone_a), 32'd1);

        // LSB-first, len 2
        @(posedge clk); #1;
        pkt_data_b = 32'hA1B2C3D4; pkt_len_b = 3'd2; pkt_valid_b = 1'b1;
        @(posedge clk); #1 pkt_valid_b = 1'b0;
        wait_until(3, 1, "t2_done_timeout");
        repeat (20) @(posedge clk);
        chk("t2_nbytes", 32'(byte_b.size()), 32'd2);
        chk("t2_b0", 32'(byte_b[0]), 32'hD4);
        chk("t2_b1", 32'(byte_b[1]), 32'hC3);
        chk("t2_ndone", 32'(ndone_b), 32'd1);

        // FIFO full: third packet refused, overflow set
        byte_a.delete(); scyc_a.delete(); nd = ndone_a;
        @(posedge clk); #1;
        pkt_data_a = 32'h11223344; pkt_len_a = 3'd2; pkt_valid_a = 1'b1;
        @(posedge clk); #1;
        pkt_data_a = 32'h55667788; pkt_len_a = 3'd1;
        @(posedge clk); #1;
        pkt_data_a = 32'h99AABBCC; pkt_len_a = 3'd0;
        @(negedge clk);
        chk("t3_ready_full", 32'(pkt_ready_a), 32'd0);
        @(posedge clk); #1 pkt_valid_a = 1'b0;
        @(negedge clk);
        chk("t3_overflow", 32'(overflow_a), 32'd1);
        wait_until(1, nd + 2, "t3_done_timeout");
        repeat (40) @(posedge clk);
        chk("t3_nbytes", 32'(byte_a.size()), 32'd3);
        chk("t3_b0", 32'(byte_a[0]), 32'h11);
        chk("t3_b1", 32'(byte_a[1]), 32'h22);
        chk("t3_b2", 32'(byte_a[2]), 32'h55);
        chk("t3_ndone", 32'(ndone_a), 32'(nd + 2));
        chk("t3_overflow_sticky", 32'(overflow_a), 32'd1);

        // busy never rises, GAP_CYC=3: spacing 1+2+1+3
        busy_cyc_b = 0;
        byte_b.delete(); scyc_b.delete(); nd = ndone_b;
        @(posedge clk); #1;
        pkt_data_b = 32'h00112233; pkt_len_b = 3'd3; pkt_valid_b = 1'b1;
        @(posedge clk); #1 pkt_valid_b = 1'b0;
        wait_until(3, nd + 1, "t4_done_timeout");
        chk("t4_nbytes", 32'(byte_b.size()), 32'd3);
        chk("t4_b0", 32'(byte_b[0]), 32'h33);
        chk("t4_b1", 32'(byte_b[1]), 32'h22);
        chk("t4_b2", 32'(byte_b[2]), 32'h11);
        chk("t4_space01", 32'(scyc_b[1] - scyc_b[0]), 32'd7);
        chk("t4_space12", 32'(scyc_b[2] - scyc_b[1]), 32'd7);

        // abort in the exact cycle of a pending send suppresses it
        repeat (3) @(posedge clk);
        byte_b.delete(); scyc_b.delete(); nd = ndone_b;
        #1;
        pkt_data_b = 32'hDEADBEEF; pkt_len_b = 3'd0; pkt_valid_b = 1'b1;
        @(posedge clk); #1 pkt_valid_b = 1'b0;
        wait_until(2, 1, "ab_first_send_timeout");
        chk("ab_b0", 32'(byte_b[0]), 32'hEF);
        repeat (7) @(posedge clk);
        #1 abort_b = 1'b1;
        @(negedge clk);
        chk("ab_send_suppressed", 32'(tx_send_b), 32'd0);
        @(posedge clk); #1 abort_b = 1'b0;
        @(negedge clk);
        chk("ab_active", 32'(active_b), 32'd0);
        repeat (30) @(posedge clk);
        chk("ab_nbytes", 32'(byte_b.size()), 32'd1);
        chk("ab_ndone", 32'(ndone_b), 32'(nd));

        // abort mid third byte with one packet queued
        byte_a.delete(); scyc_a.delete(); nd = ndone_a;
        @(posedge clk); #1;
        pkt_data_a = 32'h01020304; pkt_len_a = 3'd0; pkt_valid_a = 1'b1;
        @(posedge clk); #1;
        pkt_data_a = 32'h05060708;
        @(posedge clk); #1 pkt_valid_a = 1'b0;
        wait_until(0, 3, "t5_third_send_timeout");
        @(posedge clk); #1 abort_a = 1'b1;
        @(negedge clk);
        chk("t5_send_during_abort", 32'(tx_send_a), 32'd0);
        @(posedge clk); #1 abort_a = 1'b0;
        @(negedge clk);
        chk("t5_active", 32'(active_a), 32'd0);
        chk("t5_ready", 32'(pkt_ready_a), 32'd1);
        repeat (60) @(posedge clk);
        chk("t5_nbytes", 32'(byte_a.size()), 32'd3);
        chk("t5_b2", 32'(byte_a[2]), 32'h03);
        chk("t5_ndone", 32'(ndone_a), 32'(nd));
        chk("t5_overflow_kept", 32'(overflow_a), 32'd1);

        // reset mid-packet, then a fresh packet with len > N_BYTES
        byte_a.delete(); scyc_a.delete();
        @(posedge clk); #1;
        pkt_data_a = 32'hA1B2C3D4; pkt_len_a = 3'd0; pkt_valid_a = 1'b1;
        @(posedge clk); #1 pkt_valid_a = 1'b0;
        wait_until(0, 2, "t6_second_send_timeout");
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        chk("t6_send",     32'(tx_send_a),  32'd0);
        chk("t6_done",     32'(done_a),     32'd0);
        chk("t6_overflow", 32'(overflow_a), 32'd0);
        chk("t6_active",   32'(active_a),   32'd0);
        chk("t6_ready",    32'(pkt_ready_a), 32'd1);
        chk("t6_txdata",   32'(tx_data_a),  32'd0);
        byte_a.delete(); scyc_a.delete(); nd = ndone_a;
        @(posedge clk); #1;
        pkt_data_a = 32'h0F1E2D3C; pkt_len_a = 3'd7; pkt_valid_a = 1'b1;
        @(posedge clk); #1 pkt_valid_a = 1'b0;
        wait_until(1, nd + 1, "t6_done_timeout");
        chk("t6_nbytes", 32'(byte_a.size()), 32'd4);
        chk("t6_b0", 32'(byte_a[0]), 32'h0F);
        chk("t6_b1", 32'(byte_a[1]), 32'h1E);
        chk("t6_b2", 32'(byte_a[2]), 32'h2D);
        chk("t6_b3", 32'(byte_a[3]), 32'h3C);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
